alu_share_arb: RTL and testbench

Arbitrated front end that shares the single RV32I ALU between two requesters, such as the execute stage and a branch/address unit. It accepts operations over valid/ready handshakes and picks one per cycle by round-robin. The chosen operation is driven through one `alu` instance, and the result is registered into a one-entry response buffer with the winner's ID and tag. It sits between the issue logic and writeback/branch resolution.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 34 +++
 rtl/alu_share_arb.sv | 129 ++++++++++++
 tb/tb_alu_share_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared RV32I ALU definitions: data width, opcode encoding and the
// response-buffer state type used by the shared-ALU arbiter.
package alu_pkg;

    localparam int XLEN = 32;

    // Opcode encoding follows funct7[5]:funct3 of the RV32I OP group,
    // with PASSB occupying an otherwise unused slot.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SLL   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111,
        ALU_SUB   = 4'b1000,
        ALU_PASSB = 4'b1001,
        ALU_SRA   = 4'b1101
    } alu_op_t;

    // One-entry response buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational RV32I ALU. Unknown opcodes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] res
);

    logic [4:0] w_shamt;

    assign w_shamt = b[4:0];

    // Select the operation result; compares only ever set bit 0.
    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_SLT:   res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   res = a ^ b;
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_SLL:   res = a << w_shamt;
            ALU_SRL:   res = a >> w_shamt;
            ALU_SRA:   res = $unsigned($signed(a) >>> w_shamt);
            ALU_PASSB: res = b;
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for a single shared ALU. The
// winner's operands go through the ALU in the accepting cycle and the
// result lands in a one-entry response buffer together with ID and tag.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [XLEN-1:0]  r0_a,
    input  logic [XLEN-1:0]  r0_b,
    input  logic [3:0]       r0_op,
    input  logic [TAG_W-1:0] r0_tag,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [XLEN-1:0]  r1_a,
    input  logic [XLEN-1:0]  r1_b,
    input  logic [3:0]       r1_op,
    input  logic [TAG_W-1:0] r1_tag,

    input  logic             flush,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_res
);

    buf_state_t        r_state;
    buf_state_t        w_state_next;

    logic              r_last_grant;
    logic [XLEN-1:0]   r_res;
    logic              r_id;
    logic [TAG_W-1:0]  r_tag;

    logic              w_can_acc;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic              w_sel;
    logic [XLEN-1:0]   w_alu_a;
    logic [XLEN-1:0]   w_alu_b;
    logic [3:0]        w_alu_op;
    logic [TAG_W-1:0]  w_tag;
    logic [XLEN-1:0]   w_alu_res;

    // A new operation may enter only if the buffer is free or being drained
    // this very cycle; flush blocks acceptance outright.
    assign w_can_acc = !flush && (!rsp_valid || rsp_ready);

    // Round-robin: a lone requester wins, a tie goes to whoever did not win last.
    assign w_gnt1 = r1_valid && (!r0_valid || (r_last_grant == 1'b0));
    assign w_gnt0 = r0_valid && (!r1_valid || (r_last_grant == 1'b1));

    assign r0_ready = w_can_acc && w_gnt0;
    assign r1_ready = w_can_acc && w_gnt1;
    assign w_accept = r0_ready || r1_ready;

    // Operand mux steers the granted requester into the single ALU.
    assign w_sel    = w_gnt1;
    assign w_alu_a  = w_sel ? r1_a   : r0_a;
    assign w_alu_b  = w_sel ? r1_b   : r0_b;
    assign w_alu_op = w_sel ? r1_op  : r0_op;
    assign w_tag    = w_sel ? r1_tag : r0_tag;

    alu u_alu (
        .a   (w_alu_a),
        .b   (w_alu_b),
        .op  (w_alu_op),
        .res (w_alu_res)
    );

    // Buffer occupancy register; reset empties it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush wins, then a new acceptance refills, otherwise a drain empties.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = BUF_EMPTY;
        end else if (w_accept) begin
            w_state_next = BUF_FULL;
        end else if (rsp_ready) begin
            w_state_next = BUF_EMPTY;
        end
    end

    // Response valid is simply the buffer being full.
    always_comb begin
        rsp_valid = 1'b0;
        if (r_state == BUF_FULL) begin
            rsp_valid = 1'b1;
        end
    end

    // Payload and round-robin pointer only move on an acceptance, so data
    // fields hold their last value after a drain or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res        <= '0;
            r_id         <= 1'b0;
            r_tag        <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_res        <= w_alu_res;
            r_id         <= w_sel;
            r_tag        <= w_tag;
            r_last_grant <= w_sel;
        end
    end

    assign rsp_res = r_res;
    assign rsp_id  = r_id;
    assign rsp_tag = r_tag;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb: each task drives one scenario and
// compares against hand-computed values.
module tb_alu_share_arb;

    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             r0_valid;
    logic             r0_ready;
    logic [31:0]      r0_a;
    logic [31:0]      r0_b;
    logic [3:0]       r0_op;
    logic [TAG_W-1:0] r0_tag;
    logic             r1_valid;
    logic             r1_ready;
    logic [31:0]      r1_a;
    logic [31:0]      r1_b;
    logic [3:0]       r1_op;
    logic [TAG_W-1:0] r1_tag;
    logic             flush;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_res;

    int checks;
    int failures;

    alu_share_arb #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r0_op     (r0_op),
        .r0_tag    (r0_tag),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .r1_op     (r1_op),
        .r1_tag    (r1_tag),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_res   (rsp_res)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle just past the active edge.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic driveR0(input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        r0_valid = v; r0_op = op; r0_a = a; r0_b = b; r0_tag = tag;
    endtask

    task automatic driveR1(input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        r1_valid = v; r1_op = op; r1_a = a; r1_b = b; r1_tag = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", rsp_valid); end
        checks++;
        if (rsp_res !== 32'h0) begin failures++; $display("[TB] FAIL reset_res got=%h exp=0", rsp_res); end
        checks++;
        if (rsp_id !== 1'b0 || rsp_tag !== 4'h0) begin
            failures++; $display("[TB] FAIL reset_id_tag got=%0b/%h exp=0/0", rsp_id, rsp_tag);
        end
        rst_n = 1'b1;
        stepClk();
    endtask

    task automatic test_basic_add();
        driveR0(1'b1, 4'b0000, 32'd5, 32'd7, 4'd3);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL add_ready got=%0b%0b exp=10", r0_ready, r1_ready);
        end
        stepClk();
        r0_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd12 || rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin
            failures++;
            $display("[TB] FAIL add_rsp got=v%0b res=%h id=%0b tag=%h exp=v1 res=0000000c id=0 tag=3",
                     rsp_valid, rsp_res, rsp_id, rsp_tag);
        end
        stepClk();
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_drain got=%0b exp=0", rsp_valid); end
    endtask

    // last_grant is 0 after the ADD, so requester 1 wins the first tie here.
    task automatic test_back_to_back();
        logic        expWin;
        logic [31:0] expRes;
        logic [3:0]  expTag;
        driveR0(1'b1, 4'b1000, 32'd10, 32'd3, 4'd1);
        driveR1(1'b1, 4'b1101, 32'h8000_0000, 32'd4, 4'd2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expWin = (i % 2 == 0) ? 1'b1 : 1'b0;
            expRes = expWin ? 32'hF800_0000 : 32'd7;
            expTag = expWin ? 4'd2 : 4'd1;
            #1;
            checks++;
            if (r1_ready !== expWin || r0_ready !== !expWin) begin
                failures++; $display("[TB] FAIL b2b_grant[%0d] got=%0b%0b exp=%0b%0b", i, r0_ready, r1_ready, !expWin, expWin);
            end
            stepClk();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== expWin || rsp_res !== expRes || rsp_tag !== expTag) begin
                failures++;
                $display("[TB] FAIL b2b_rsp[%0d] got=v%0b id=%0b res=%h tag=%h exp=v1 id=%0b res=%h tag=%h",
                         i, rsp_valid, rsp_id, rsp_res, rsp_tag, expWin, expRes, expTag);
            end
        end
    endtask

    task automatic test_stall();
        driveR0(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'd5);
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (r0_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_fill_ready got=%0b exp=1", r0_ready); end
        stepClk();
        rsp_ready = 1'b0;
        driveR1(1'b1, 4'b0001, 32'd1, 32'd31, 4'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
                failures++; $display("[TB] FAIL stall_ready[%0d] got=%0b%0b exp=00", i, r0_ready, r1_ready);
            end
            stepClk();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_res !== 32'd1 || rsp_id !== 1'b0 || rsp_tag !== 4'd5) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d] got=v%0b res=%h id=%0b tag=%h exp=v1 res=1 id=0 tag=5",
                         i, rsp_valid, rsp_res, rsp_id, rsp_tag);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_release_grant got=%0b%0b exp=01", r0_ready, r1_ready);
        end
        stepClk();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'h8000_0000 || rsp_id !== 1'b1 || rsp_tag !== 4'd7) begin
            failures++;
            $display("[TB] FAIL stall_sll_rsp got=v%0b res=%h id=%0b tag=%h exp=v1 res=80000000 id=1 tag=7",
                     rsp_valid, rsp_res, rsp_id, rsp_tag);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        stepClk();
    endtask

    task automatic test_opcodes();
        logic [3:0]  ops  [10];
        logic [31:0] as   [10];
        logic [31:0] bs   [10];
        logic [31:0] exps [10];
        ops[0] = 4'b0011; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd1;          exps[0] = 32'd0;
        ops[1] = 4'b0010; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd1;          exps[1] = 32'd1;
        ops[2] = 4'b0100; as[2] = 32'h0000_0F0F; bs[2] = 32'h0000_00FF;  exps[2] = 32'h0000_0FF0;
        ops[3] = 4'b0110; as[3] = 32'h0000_0F0F; bs[3] = 32'h0000_00FF;  exps[3] = 32'h0000_0FFF;
        ops[4] = 4'b0111; as[4] = 32'h0000_0F0F; bs[4] = 32'h0000_00FF;  exps[4] = 32'h0000_000F;
        ops[5] = 4'b0101; as[5] = 32'h8000_0000; bs[5] = 32'h0000_0024;  exps[5] = 32'h0800_0000;
        ops[6] = 4'b1001; as[6] = 32'd1;         bs[6] = 32'hDEAD_BEEF;  exps[6] = 32'hDEAD_BEEF;
        ops[7] = 4'b0000; as[7] = 32'hFFFF_FFFF; bs[7] = 32'd1;          exps[7] = 32'd0;
        ops[8] = 4'b1111; as[8] = 32'd5;         bs[8] = 32'd5;          exps[8] = 32'd0;
        ops[9] = 4'b1010; as[9] = 32'd9;         bs[9] = 32'd3;          exps[9] = 32'd0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            driveR0(1'b1, ops[i], as[i], bs[i], 4'(i));
            #1;
            checks++;
            if (r0_ready !== 1'b1) begin failures++; $display("[TB] FAIL op_ready[%0d] got=%0b exp=1", i, r0_ready); end
            stepClk();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_res !== exps[i] || rsp_tag !== 4'(i)) begin
                failures++;
                $display("[TB] FAIL op_rsp[%0d] op=%b got=v%0b res=%h tag=%h exp=v1 res=%h tag=%h",
                         i, ops[i], rsp_valid, rsp_res, rsp_tag, exps[i], 4'(i));
            end
        end
        r0_valid = 1'b0;
        stepClk();
    endtask

    // Both requesters stay valid across the flush; r1 must win afterwards,
    // which only holds if the flush left last_grant at 0.
    task automatic test_flush();
        driveR0(1'b1, 4'b0000, 32'd1, 32'd1, 4'd8);
        rsp_ready = 1'b1;
        stepClk();
        driveR0(1'b1, 4'b0000, 32'd4, 32'd4, 4'd10);
        driveR1(1'b1, 4'b0000, 32'd2, 32'd3, 4'd9);
        flush = 1'b1;
        #1;
        checks++;
        if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_ready got=%0b%0b exp=00", r0_ready, r1_ready);
        end
        stepClk();
        flush = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_res !== 32'd2) begin
            failures++; $display("[TB] FAIL flush_empty got=v%0b res=%h exp=v0 res=2", rsp_valid, rsp_res);
        end
        #1;
        checks++;
        if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_after_grant got=%0b%0b exp=01", r0_ready, r1_ready);
        end
        stepClk();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd5 || rsp_id !== 1'b1 || rsp_tag !== 4'd9) begin
            failures++;
            $display("[TB] FAIL flush_r1_rsp got=v%0b res=%h id=%0b tag=%h exp=v1 res=5 id=1 tag=9",
                     rsp_valid, rsp_res, rsp_id, rsp_tag);
        end
        r1_valid = 1'b0;
        stepClk();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd8 || rsp_id !== 1'b0 || rsp_tag !== 4'd10) begin
            failures++;
            $display("[TB] FAIL flush_r0_rsp got=v%0b res=%h id=%0b tag=%h exp=v1 res=8 id=0 tag=a",
                     rsp_valid, rsp_res, rsp_id, rsp_tag);
        end
    endtask

    // Buffer is FULL with r0 as last winner; reset must clear it without a
    // clock edge and restore the tie-break towards r0.
    task automatic test_async_reset();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_res !== 32'd0 || rsp_tag !== 4'd0) begin
            failures++;
            $display("[TB] FAIL async_reset got=v%0b res=%h tag=%h exp=v0 res=0 tag=0", rsp_valid, rsp_res, rsp_tag);
        end
        stepClk();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        driveR0(1'b1, 4'b0000, 32'd0, 32'd0, 4'd11);
        driveR1(1'b1, 4'b0000, 32'd0, 32'd0, 4'd12);
        #1;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset_tie got=%0b%0b exp=10", r0_ready, r1_ready);
        end
        stepClk();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd11) begin
            failures++; $display("[TB] FAIL post_reset_rsp got=v%0b id=%0b tag=%h exp=v1 id=0 tag=b", rsp_valid, rsp_id, rsp_tag);
        end
        #1;
        checks++;
        if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset_next got=%0b%0b exp=01", r0_ready, r1_ready);
        end
        stepClk();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        rsp_ready = 1'b0;
        driveR0(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
        driveR1(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_stall();
        test_opcodes();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
